// File: rtl/sr_latch_bank.sv
// Bank of WIDTH clocked set/reset storage bits with a fixed S=R=1 resolution,
// registered rise/fall/conflict flags and a saturating conflict counter.
module sr_latch_bank #(
   parameter int                 WIDTH   = 8,
   parameter int                 MODE    = 0,
   parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}},
   parameter int                 CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  S,
   input  logic [WIDTH-1:0]  R,
   input  logic              clr_cnt,
   output logic [WIDTH-1:0]  Q,
   output logic [WIDTH-1:0]  Q_bar,
   output logic [WIDTH-1:0]  rise,
   output logic [WIDTH-1:0]  fall,
   output logic [WIDTH-1:0]  conflict,
   output logic [CNT_W-1:0]  conflict_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   if (MODE < 0 || MODE > 3) begin : g_bad_mode
      $error("sr_latch_bank: MODE must be 0..3");
   end
   if (WIDTH < 1 || CNT_W < 1) begin : g_bad_width
      $error("sr_latch_bank: WIDTH and CNT_W must be at least 1");
   end

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] both;
   logic             any_conflict;
   logic [CNT_W-1:0] cnt_next;

   assign both         = S & R;
   assign any_conflict = |both;

   always_comb begin
      q_next = Q;
      for (int i = 0; i < WIDTH; i++) begin
         unique case ({S[i], R[i]})
            2'b10:   q_next[i] = 1'b1;
            2'b01:   q_next[i] = 1'b0;
            2'b11: begin
               case (MODE)
                  0:       q_next[i] = 1'b1;
                  1:       q_next[i] = 1'b0;
                  2:       q_next[i] = Q[i];
                  default: q_next[i] = ~Q[i];
               endcase
            end
            default: q_next[i] = Q[i];
         endcase
      end
   end

   // Clear has priority over a same-edge increment; the count never wraps.
   always_comb begin
      cnt_next = conflict_cnt;
      if (clr_cnt) begin
         cnt_next = '0;
      end else if (any_conflict && conflict_cnt != CNT_MAX) begin
         cnt_next = conflict_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Q            <= RST_VAL;
         rise         <= '0;
         fall         <= '0;
         conflict     <= '0;
         conflict_cnt <= '0;
      end else begin
         Q            <= q_next;
         rise         <= q_next & ~Q;
         fall         <= ~q_next & Q;
         conflict     <= both;
         conflict_cnt <= cnt_next;
      end
   end

   assign Q_bar = ~Q;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Scoreboard bench: four banks (one per MODE) share stimulus; a reference
// model queues the expected outputs and a negedge monitor compares them.
module tb_sr_latch_bank;

   localparam logic [7:0] RV = 8'hA5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] s_in = '0;
   logic [7:0] r_in = '0;
   logic       clr = 1'b0;

   logic [3:0][7:0] q_a, qb_a, rise_a, fall_a, conf_a;
   logic [1:0] cnt0;
   logic [7:0] cnt1, cnt2;
   logic [2:0] cnt3;

   always #5 clk = ~clk;

   sr_latch_bank #(.WIDTH(8), .MODE(0), .RST_VAL(RV), .CNT_W(2)) u_m0 (
      .clk(clk), .rst(rst), .S(s_in), .R(r_in), .clr_cnt(clr),
      .Q(q_a[0]), .Q_bar(qb_a[0]), .rise(rise_a[0]), .fall(fall_a[0]),
      .conflict(conf_a[0]), .conflict_cnt(cnt0));
   sr_latch_bank #(.WIDTH(8), .MODE(1), .RST_VAL(RV), .CNT_W(8)) u_m1 (
      .clk(clk), .rst(rst), .S(s_in), .R(r_in), .clr_cnt(clr),
      .Q(q_a[1]), .Q_bar(qb_a[1]), .rise(rise_a[1]), .fall(fall_a[1]),
      .conflict(conf_a[1]), .conflict_cnt(cnt1));
   sr_latch_bank #(.WIDTH(8), .MODE(2), .RST_VAL(RV), .CNT_W(8)) u_m2 (
      .clk(clk), .rst(rst), .S(s_in), .R(r_in), .clr_cnt(clr),
      .Q(q_a[2]), .Q_bar(qb_a[2]), .rise(rise_a[2]), .fall(fall_a[2]),
      .conflict(conf_a[2]), .conflict_cnt(cnt2));
   sr_latch_bank #(.WIDTH(8), .MODE(3), .RST_VAL(RV), .CNT_W(3)) u_m3 (
      .clk(clk), .rst(rst), .S(s_in), .R(r_in), .clr_cnt(clr),
      .Q(q_a[3]), .Q_bar(qb_a[3]), .rise(rise_a[3]), .fall(fall_a[3]),
      .conflict(conf_a[3]), .conflict_cnt(cnt3));

   typedef struct packed {
      logic [3:0][7:0] q;
      logic [3:0][7:0] rise;
      logic [3:0][7:0] fall;
      logic [7:0]      conf;
      logic [3:0][7:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   // Reference state: per-mode channel values and counter values.
   int m_q   [4][8];
   int m_cnt [4];
   int m_max [4] = '{3, 255, 255, 7};

   task automatic chk(input string name, input int m, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s mode%0d at %0t: got %02h want %02h", name, m, $time, act, req);
      end
   endtask

   // Applies one edge's worth of inputs and queues what every bank should show after it.
   task automatic step(input logic rst_v, input logic clr_v, input logic [7:0] s_v, input logic [7:0] r_v);
      exp_t e;
      logic [7:0] sv, rv;
      int nq;
      bit conflict_any;
      sv = s_v;
      rv = r_v;
      rst = rst_v;
      clr = clr_v;
      s_in = s_v;
      r_in = r_v;
      e = '0;
      conflict_any = 0;
      for (int i = 0; i < 8; i++) if (sv[i] && rv[i]) conflict_any = 1;
      for (int m = 0; m < 4; m++) begin
         for (int i = 0; i < 8; i++) begin
            if (rst_v) begin
               nq = RV[i] ? 1 : 0;
            end else if (sv[i] && !rv[i]) begin
               nq = 1;
            end else if (!sv[i] && rv[i]) begin
               nq = 0;
            end else if (sv[i] && rv[i]) begin
               if (m == 0) nq = 1;
               else if (m == 1) nq = 0;
               else if (m == 2) nq = m_q[m][i];
               else nq = 1 - m_q[m][i];
            end else begin
               nq = m_q[m][i];
            end
            if (!rst_v) begin
               e.rise[m][i] = (m_q[m][i] == 0 && nq == 1);
               e.fall[m][i] = (m_q[m][i] == 1 && nq == 0);
            end
            m_q[m][i] = nq;
            e.q[m][i] = (nq == 1);
         end
         if (rst_v || clr_v) m_cnt[m] = 0;
         else if (conflict_any && m_cnt[m] < m_max[m]) m_cnt[m] = m_cnt[m] + 1;
         e.cnt[m] = 8'(m_cnt[m]);
      end
      if (!rst_v) e.conf = sv & rv;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [3:0][7:0] cnt_a;
         e = exp_q.pop_front();
         cnt_a[0] = {6'b0, cnt0};
         cnt_a[1] = cnt1;
         cnt_a[2] = cnt2;
         cnt_a[3] = {5'b0, cnt3};
         for (int m = 0; m < 4; m++) begin
            chk("q",     m, q_a[m],    e.q[m]);
            chk("q_bar", m, qb_a[m],   ~e.q[m]);
            chk("rise",  m, rise_a[m], e.rise[m]);
            chk("fall",  m, fall_a[m], e.fall[m]);
            chk("conf",  m, conf_a[m], e.conf);
            chk("cnt",   m, cnt_a[m],  e.cnt[m]);
         end
      end
   end

   initial begin
      int wait_cycles;
      logic [7:0] sr, rr;
      for (int m = 0; m < 4; m++) begin
         m_cnt[m] = 0;
         for (int i = 0; i < 8; i++) m_q[m][i] = 0;
      end

      // Reset with every other input active, then idle.
      step(1, 1, 8'hFF, 8'hFF);
      repeat (3) step(0, 0, 8'h00, 8'h00);

      // Basic set / clear from 00.
      step(0, 0, 8'h00, 8'hFF);
      step(0, 0, 8'h0F, 8'h00);
      step(0, 0, 8'h00, 8'h00);
      step(0, 0, 8'h00, 8'h03);

      // Conflict resolution from 0F with a freshly cleared counter.
      step(0, 1, 8'h0F, 8'hF0);
      step(0, 0, 8'hFF, 8'hFF);
      step(0, 0, 8'h00, 8'h00);

      // Toggle run on bit 0 from 00.
      step(0, 1, 8'h00, 8'hFF);
      repeat (4) step(0, 0, 8'h01, 8'h01);

      // Saturation then clear against a simultaneous conflict.
      step(0, 1, 8'h00, 8'h00);
      repeat (5) step(0, 0, 8'h81, 8'h80);
      step(0, 1, 8'h10, 8'h10);
      step(0, 0, 8'h10, 8'h10);

      // Reset in the middle of a toggle run.
      repeat (3) step(0, 0, 8'hFF, 8'hFF);
      step(1, 0, 8'hFF, 8'hFF);
      step(0, 0, 8'h00, 8'h00);
      step(0, 0, 8'h00, 8'h00);

      // Randomised traffic with occasional reset and clear.
      for (int n = 0; n < 400; n++) begin
         sr = 8'($urandom) & 8'($urandom);
         rr = 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 3) == 0) rr = rr | sr;
         step($urandom_range(0, 40) == 0, $urandom_range(0, 20) == 0, sr, rr);
      end
      step(0, 0, 8'h00, 8'h00);

      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sr_latch_bank.md
# sr_latch_bank

Parametrised, clocked successor to the single-bit NOR SR latch: a bank of `WIDTH` independent set/reset storage bits, all updated on one clock. It has a compile-time resolution mode for the S=R=1 case, per-bit transition pulses, and a per-bit conflict flag. A saturating conflict counter lets control logic detect misuse of the set/reset lines. It sits wherever the design needs sticky status bits (interrupt pending, error capture, handshake flags) without the timing hazards of a combinational latch.

## Interface
- `WIDTH`, 8: number of independent SR channels (≥1).
- `MODE`, 0: S=R=1 resolution, identical for all channels.
  - 0 = set-dominant.
  - 1 = reset-dominant.
  - 2 = hold.
  - 3 = toggle.
  - Any other value is an elaboration-time error.
- `RST_VAL`, {WIDTH{1'b0}}: value loaded into `Q` by reset.
- `CNT_W`, 8: width of the conflict counter (≥1).

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `S`  in  WIDTH  per-channel set request, sampled each rising edge.
- `R`  in  WIDTH  per-channel reset request, sampled each rising edge.
- `clr_cnt`  in  1  synchronous clear of `conflict_cnt`.
- `Q`  out  WIDTH  registered channel state.
- `Q_bar`  out  WIDTH  bitwise inverse of `Q`, always exactly `~Q` (no forbidden 0/0 state).
- `rise`  out  WIDTH  one-cycle pulse, registered, high in the cycle where `Q[i]` first reads 1 after 0.
- `fall`  out  WIDTH  one-cycle pulse, registered, high in the cycle where `Q[i]` first reads 0 after 1.
- `conflict`  out  WIDTH  registered; `conflict[i]`=1 iff S[i]&R[i] was sampled at the previous edge.
- `conflict_cnt`  out  CNT_W  saturating count of edges at which any channel had S&R.

## Operation
- Per channel i at each rising edge (rst=0), next Q[i] from (S[i],R[i]):
  - 00: hold.
  - 10: 1.
  - 01: 0.
  - 11: by MODE — 0: 1, 1: 0, 2: hold, 3: ~Q[i].
- Channels are fully independent; no cross-channel interaction except `conflict_cnt`.
- rise[i] = (next Q[i]==1 && Q[i]==0), registered with Q. fall[i] is symmetric. Setting an already-set bit gives no pulse.
- MODE 3 with S=R=1 held N cycles toggles Q every cycle. rise/fall then alternate each cycle and conflict stays 1.
- conflict_cnt:
  - Increments by exactly 1 per edge at which |(S&R) is 1, independent of how many channels conflict.
  - Saturates at 2^CNT_W−1 and never wraps.
- clr_cnt=1 forces conflict_cnt to 0 at the edge. Clear wins over a simultaneous increment, so the result is 0, not 1.
- Reset values (rst=1 at an edge, dominates all other inputs):
  - Q=RST_VAL, Q_bar=~RST_VAL.
  - rise=0, fall=0, conflict=0, conflict_cnt=0.
- Reset never produces rise/fall pulses, even if Q changes value.
- Reset mid-operation (e.g. during a MODE 3 toggle run) aborts immediately. The first post-reset edge evaluates S/R against RST_VAL.

## Timing
- Latency: S/R sampled at edge k appear on Q, rise, fall and conflict after edge k; visible during cycle k+1.
- conflict_cnt reflects edge k after edge k, i.e. the same cycle as `conflict`.
- Q_bar is combinational from the Q register only: no input-to-output combinational path anywhere in the block.
- Inputs need only meet setup/hold to clk. No synchronisers inside; asynchronous sources must be synchronised upstream.

## Test plan
- Reset, RST_VAL=8'hA5:
  - After rst edge: Q=A5, Q_bar=5A, rise=fall=conflict=0, cnt=0.
  - Release, hold S=R=0 for 3 edges: Q stays A5, no pulses.
- Basic set/clear, WIDTH=8, MODE=0, from Q=00:
  - S=8'h0F one edge → Q=0F, rise=0F.
  - Next edge with S=R=0 → rise=00.
  - Then R=8'h03 → Q=0C, fall=03.
- Conflict resolution, per MODE 0/1/2/3, S=R=8'hFF one edge from Q=8'h0F:
  - MODE 0 → Q=FF. MODE 1 → Q=00. MODE 2 → Q=0F. MODE 3 → Q=F0.
  - conflict=FF in every mode; cnt=1.
- Toggle run, MODE 3, S=R=1 on bit0 for 4 edges from Q=0:
  - Q[0] sequence 1,0,1,0.
  - rise/fall alternate.
  - cnt=4 (counter counts edges, not channels).
- Counter saturation/clear, CNT_W=2:
  - 5 conflict edges → cnt 1,2,3,3,3.
  - clr_cnt with a simultaneous conflict → cnt=0.
  - Next conflict edge → cnt=1.
- Reset mid-operation, MODE 3:
  - During a toggle run assert rst with S=R=FF → Q=RST_VAL, no rise/fall, cnt=0.
  - Release rst with S=R=0 → Q holds RST_VAL.
